// File: rtl/chimp_board_responder_pkg.sv
// Shared constants, FSM state encoding and LFSR step function for the chimp board.
package chimp_pkg;

  localparam int          NUM_TILES     = 32;
  localparam int          TILE_W        = 5;
  localparam int          NUM_W         = 5;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
  // Feedback taps 16,14,13,11 expressed as state bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLACE = 2'd1,
    ST_READY = 2'd2
  } state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/chimp_lfsr16.sv
// 16-bit Fibonacci LFSR, free-running every cycle; loads SEED on synchronous reset.
module chimp_lfsr16
  import chimp_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        iReset,
  output logic [15:0] oState
);

  logic [15:0] state_q, state_d;

  assign state_d = lfsr_next(state_q);
  assign oState  = state_q;

  always_ff @(posedge clk) begin
    if (iReset) state_q <= SEED;
    else        state_q <= state_d;
  end

endmodule

// File: rtl/chimp_board_responder.sv
// Chimp-test board: random placement of 1..level, click judging, renderer read port.
// Optional CHIMP_HIDE_EN adds a hide flag that masks numbers after the first correct click.
module chimp_board_responder
  import chimp_pkg::*;
#(
  parameter int          NUM_TILES  = 32,
  parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEF
) (
  input  logic       clk,
  input  logic       iReset,
  input  logic       iResetBoard,
  input  logic       iLoadEnable,
  input  logic [4:0] iLevel,
  input  logic [4:0] iNumToChoose,
  input  logic       iClickValid,
  input  logic [4:0] iClickTile,
  input  logic [4:0] iRdTile,
  output logic [4:0] oRdNum,
  output logic       oRdHidden,
  output logic       oLoadBusy,
  output logic       oChoseCorrectNum,
  output logic       oChoseWrongNum
);

  state_t            state_q, state_d;
  logic [NUM_W-1:0]  board_q [NUM_TILES];
  logic              loaded_q, loaded_d;
  logic [NUM_W-1:0]  n_q, n_d, level_q, level_d;
  logic [TILE_W-1:0] probe_q, probe_d;
  logic              correct_q, correct_d, wrong_q, wrong_d;
  logic [15:0]       lfsr_w;
  logic              unused_lfsr;

  logic [NUM_W-1:0]  probe_num, click_num;
  logic              start, place_wr, place_last, click, click_hit, click_miss, level_done;

  chimp_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .iReset (iReset),
    .oState (lfsr_w)
  );

  assign unused_lfsr = ^lfsr_w[15:5];

  assign probe_num  = board_q[probe_q];
  assign click_num  = board_q[iClickTile];
  assign start      = ~iReset & (state_q == ST_IDLE) & iLoadEnable & ~iResetBoard & ~loaded_q;
  assign place_wr   = (state_q == ST_PLACE) & ~iResetBoard & (probe_num == '0);
  assign place_last = place_wr & (n_q == level_q);
  assign click      = (state_q == ST_READY) & ~iResetBoard & iClickValid & (iNumToChoose != '0);
  assign click_hit  = click & (click_num == iNumToChoose);
  assign click_miss = click & (click_num != '0) & (click_num != iNumToChoose);
  assign level_done = click_hit & (iNumToChoose == level_q);

  always_ff @(posedge clk) begin
    if (iReset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (iLevel == '0) ? ST_READY : ST_PLACE;
      ST_PLACE: begin
        if (iResetBoard)     state_d = ST_IDLE;
        else if (place_last) state_d = ST_READY;
      end
      ST_READY: begin
        if (iResetBoard)     state_d = ST_IDLE;
        else if (level_done) state_d = ST_IDLE;
      end
      default:               state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    oLoadBusy = start | (state_q == ST_PLACE);
    n_d       = n_q;
    probe_d   = probe_q;
    level_d   = level_q;
    loaded_d  = loaded_q;
    correct_d = click_hit;
    wrong_d   = click_miss;
    if (start) begin
      n_d     = 5'd1;
      probe_d = lfsr_w[4:0];
      level_d = iLevel;
      if (iLevel == '0) loaded_d = 1'b1;
    end
    // Occupied probe walks linearly and wraps at 32, so an empty tile is found in <=32 cycles.
    if (place_wr) begin
      n_d     = n_q + 5'd1;
      probe_d = lfsr_w[4:0];
      if (place_last) loaded_d = 1'b1;
    end else if ((state_q == ST_PLACE) && !iResetBoard) begin
      probe_d = probe_q + 5'd1;
    end
    if (level_done || iResetBoard) loaded_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (iReset) begin
      loaded_q  <= 1'b0;
      n_q       <= '0;
      level_q   <= '0;
      probe_q   <= '0;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
    end else begin
      loaded_q  <= loaded_d;
      n_q       <= n_d;
      level_q   <= level_d;
      probe_q   <= probe_d;
      correct_q <= correct_d;
      wrong_q   <= wrong_d;
    end
  end

  always_ff @(posedge clk) begin
    if (iReset || iResetBoard) begin
      for (int i = 0; i < NUM_TILES; i++) board_q[i] <= '0;
    end else begin
      if (place_wr)  board_q[probe_q]    <= n_q;
      if (click_hit) board_q[iClickTile] <= '0;
    end
  end

  assign oRdNum           = board_q[iRdTile];
  assign oChoseCorrectNum = correct_q;
  assign oChoseWrongNum   = wrong_q;

`ifdef CHIMP_HIDE_EN
  logic hide_q, hide_d;

  always_comb begin
    hide_d = hide_q;
    if (click_hit)            hide_d = 1'b1;
    if (start || iResetBoard) hide_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (iReset) hide_q <= 1'b0;
    else        hide_q <= hide_d;
  end

  assign oRdHidden = hide_q;
`else
  assign oRdHidden = 1'b0;
`endif

endmodule

// File: doc/chimp_board_responder.md
CHIMP_BOARD_RESPONDER -- requirements
Module: chimp_board_responder

Interface
REQ-001 SHALL use parameter NUM_TILES, default 32, meaning the number of board tiles (fixed at 32; tile index 5 bits).
REQ-002 SHALL use parameter LFSR_SEED, default 16'hACE1, meaning the placement LFSR value loaded on reset.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on posedge.
REQ-004 SHALL have port iReset, input, 1, synchronous active-high reset; clock clk.
REQ-005 SHALL have port iResetBoard, input, 1, controller board-clear request (level-1 sense).
REQ-006 SHALL have port iLoadEnable, input, 1, controller load window.
REQ-007 SHALL have port iLevel, input, 5, count of numbers to place (1..31).
REQ-008 SHALL have port iNumToChoose, input, 5, number the controller expects next; 0 means no choice is open.
REQ-009 SHALL have port iClickValid, input, 1, one-cycle click strobe.
REQ-010 SHALL have port iClickTile, input, 5, clicked tile index.
REQ-011 SHALL have port iRdTile, input, 5, renderer read address.
REQ-012 SHALL have port oRdNum, output, 5, number stored at iRdTile (0 = empty), combinational read.
REQ-013 SHALL have port oRdHidden, output, 1, renderer must mask the number shown on occupied tiles.
REQ-014 SHALL have port oLoadBusy, output, 1, placement in progress; drives the controller's iDoneLoad.
REQ-015 SHALL have port oChoseCorrectNum, output, 1, one-cycle pulse.
REQ-016 SHALL have port oChoseWrongNum, output, 1, one-cycle pulse.

Function
REQ-017 SHALL hold a board array of 32 x 5-bit entries, a loaded flag, and a 16-bit Fibonacci LFSR (taps 16,14,13,11) advancing every cycle, including while idle.
REQ-018 SHALL implement FSM IDLE -> PLACE -> READY -> IDLE.
REQ-019 IDLE: iResetBoard clears all entries and the loaded flag in one cycle; iLoadEnable & ~iResetBoard & ~loaded -> PLACE with n=1, probe=lfsr[4:0].
REQ-020 SHALL drive oLoadBusy combinationally high in the IDLE start cycle and throughout PLACE, so the controller sees busy on its first load cycle.
REQ-021 PLACE: if board[probe]==0, write n, then n++ and probe=lfsr[4:0]; else probe=(probe+1) mod 32 (wrap); each number SHALL place within at most 32 cycles.
REQ-022 PLACE -> READY in the cycle after writing n==iLevel (iLevel sampled at PLACE entry); loaded set. iLevel==0 SHALL go directly to READY with an empty board.
REQ-023 READY: on iClickValid with iNumToChoose!=0: board[iClickTile]==iNumToChoose -> oChoseCorrectNum pulses next cycle and the entry clears; a nonzero mismatch -> oChoseWrongNum pulses next cycle, board unchanged; an empty tile is ignored.
REQ-024 SHALL ignore clicks in IDLE/PLACE and when iNumToChoose==0; the two pulses SHALL never assert together.
REQ-025 A correct click with iNumToChoose==level SHALL clear loaded and return to IDLE, so the next load window re-places numbers (level-up path).
REQ-026 iResetBoard in PLACE or READY SHALL clear the board and loaded flag and force IDLE; it takes priority over a simultaneous click.

Reset
REQ-027 iReset SHALL clear the board, loaded flag, FSM (IDLE), pulses (0), and hide flag, and SHALL load LFSR_SEED; oLoadBusy=0 and oRdNum=0 after reset; iReset overrides all inputs.

Configuration
REQ-028 With CHIMP_HIDE_EN defined, a hide flag SHALL set on the first correct click after a placement, clear on placement start or iResetBoard, and drive oRdHidden; without it, oRdHidden SHALL be constant 0 and no flag exists.

Structure
REQ-029 Package chimp_pkg SHALL hold NUM_TILES, TILE_W=5, NUM_W=5, the LFSR seed/taps, and the FSM state enum.
REQ-030 The LFSR SHALL be sub-module chimp_lfsr16 (clk, iReset, seed parameter, 16-bit state out).

Verification
REQ-031 Reset, then iLoadEnable=1, iLevel=4 -> oLoadBusy high the same cycle and falls within 128 cycles; exactly tiles holding 1..4 exist, each unique.
REQ-032 After a level-4 load, iNumToChoose=1 with a click on the tile holding 1 -> oChoseCorrectNum=1 for exactly one cycle, and that tile reads 0.
REQ-033 iNumToChoose=2 with a click on the tile holding 3 -> oChoseWrongNum one cycle, board unchanged; a click on an empty tile -> no pulse.
REQ-034 Force the LFSR to collide on occupied tile 31 -> probe wraps to tile 0; placement completes correctly.
REQ-035 iResetBoard asserted mid-PLACE at iLevel=20 -> IDLE next cycle, all 32 tiles read 0, oLoadBusy=0.
REQ-036 With CHIMP_HIDE_EN, the first correct click -> oRdHidden=1 until the next placement; without it, oRdHidden stays 0 throughout.
